// File: rtl/gb_stream_pkg.sv
// Shared types and constants for the gray-balance output stream transmitter.
package gb_stream_pkg;

    typedef enum logic [3:0] {
        StIdle   = 4'b0001,
        StCtrl   = 4'b0010,
        StHeader = 4'b0100,
        StPixels = 4'b1000
    } state_t;

    localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;
    localparam logic [3:0] PKT_TYPE_CTRL  = 4'hF;
    localparam int unsigned CTRL_NIBBLES  = 9;
    localparam logic [3:0] INTERLACE_PROG = 4'h3;

    // Control-packet payload nibble for beat idx (1..9); beat 0 is the type nibble.
    function automatic logic [3:0] ctrl_nibble(input logic [3:0] idx, input logic [15:0] w,
                                               input logic [15:0] h);
        logic [3:0] nib;
        case (idx)
            4'd1:    nib = w[15:12];
            4'd2:    nib = w[11:8];
            4'd3:    nib = w[7:4];
            4'd4:    nib = w[3:0];
            4'd5:    nib = h[15:12];
            4'd6:    nib = h[11:8];
            4'd7:    nib = h[7:4];
            4'd8:    nib = h[3:0];
            4'd9:    nib = INTERLACE_PROG;
            default: nib = PKT_TYPE_CTRL;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/gb_stream_out_reg.sv
// Single-entry output holding register with valid/ready handshake and SOP/EOP flags.
module gb_stream_out_reg #(
    parameter int unsigned DATA_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_req,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_sop,
    input  logic                  load_eop,
    input  logic                  dout_ready,
    output logic                  can_load,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket
);

    assign can_load = !dout_valid || dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid         <= 1'b0;
            dout_data          <= '0;
            dout_startofpacket <= 1'b0;
            dout_endofpacket   <= 1'b0;
        end else if (can_load) begin
            dout_valid <= load_req;
            // Payload only changes on a real load so a drained register keeps its last beat.
            if (load_req) begin
                dout_data          <= load_data;
                dout_startofpacket <= load_sop;
                dout_endofpacket   <= load_eop;
            end
        end
    end

endmodule

// File: rtl/gb_stream_tx.sv
// Avalon-ST video packet transmitter: header beat then W*H pixels with SOP/EOP framing.
// Define GB_STREAM_TX_CTRL_PKT_EN to prepend a 10-beat control packet to every frame.
module gb_stream_tx
    import gb_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 14,
    parameter int unsigned DIM_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  frame_width,
    input  logic [DIM_WIDTH-1:0]  frame_height,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DATA_WIDTH-1:0] din_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    output logic                  busy
);

    state_t                state;
    logic [DIM_WIDTH-1:0]  x_cnt;
    logic [DIM_WIDTH-1:0]  y_cnt;
    logic [DIM_WIDTH-1:0]  w_lat;
    logic [DIM_WIDTH-1:0]  h_lat;
    logic [DIM_WIDTH-1:0]  w_last;
    logic [DIM_WIDTH-1:0]  h_last;
`ifdef GB_STREAM_TX_CTRL_PKT_EN
    logic [3:0]            nib_cnt;
`endif

    logic                  can_load;
    logic                  load_req;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_sop;
    logic                  load_eop;
    logic                  xfer;
    logic                  x_at_end;
    logic                  last_pix;

    assign w_last   = w_lat - DIM_WIDTH'(1);
    assign h_last   = h_lat - DIM_WIDTH'(1);
    assign x_at_end = (x_cnt == w_last);
    assign last_pix = x_at_end && (y_cnt == h_last);

    assign din_ready = (state == StPixels) && can_load;
    assign xfer      = din_valid && din_ready;
    assign busy      = (state != StIdle) || dout_valid;

    always_comb begin
        load_req  = 1'b0;
        load_data = '0;
        load_sop  = 1'b0;
        load_eop  = 1'b0;
        unique case (state)
`ifdef GB_STREAM_TX_CTRL_PKT_EN
            StCtrl: begin
                load_req  = 1'b1;
                load_data = DATA_WIDTH'(ctrl_nibble(nib_cnt, 16'(w_lat), 16'(h_lat)));
                load_sop  = (nib_cnt == 4'd0);
                load_eop  = (nib_cnt == 4'(CTRL_NIBBLES));
            end
`endif
            StHeader: begin
                load_req  = 1'b1;
                load_data = DATA_WIDTH'(PKT_TYPE_VIDEO);
                load_sop  = 1'b1;
            end
            StPixels: begin
                load_req  = din_valid;
                load_data = din_data;
                load_eop  = last_pix;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
            x_cnt <= '0;
            y_cnt <= '0;
            w_lat <= '0;
            h_lat <= '0;
`ifdef GB_STREAM_TX_CTRL_PKT_EN
            nib_cnt <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (start && (frame_width != '0) && (frame_height != '0)) begin
                        w_lat <= frame_width;
                        h_lat <= frame_height;
                        x_cnt <= '0;
                        y_cnt <= '0;
`ifdef GB_STREAM_TX_CTRL_PKT_EN
                        nib_cnt <= '0;
                        state   <= StCtrl;
`else
                        state <= StHeader;
`endif
                    end
                end
`ifdef GB_STREAM_TX_CTRL_PKT_EN
                StCtrl: begin
                    if (can_load) begin
                        if (nib_cnt == 4'(CTRL_NIBBLES)) begin
                            state <= StHeader;
                        end else begin
                            nib_cnt <= nib_cnt + 4'd1;
                        end
                    end
                end
`endif
                StHeader: begin
                    if (can_load) begin
                        state <= StPixels;
                    end
                end
                StPixels: begin
                    if (xfer) begin
                        if (x_at_end) begin
                            x_cnt <= '0;
                            if (y_cnt == h_last) begin
                                y_cnt <= '0;
                                state <= StIdle;
                            end else begin
                                y_cnt <= y_cnt + DIM_WIDTH'(1);
                            end
                        end else begin
                            x_cnt <= x_cnt + DIM_WIDTH'(1);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    gb_stream_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk                (clk),
        .rst                (rst),
        .load_req           (load_req),
        .load_data          (load_data),
        .load_sop           (load_sop),
        .load_eop           (load_eop),
        .dout_ready         (dout_ready),
        .can_load           (can_load),
        .dout_valid         (dout_valid),
        .dout_data          (dout_data),
        .dout_startofpacket (dout_startofpacket),
        .dout_endofpacket   (dout_endofpacket)
    );

endmodule

// File: tb/tb_gb_stream_tx.sv
// Directed bench for gb_stream_tx; expected beats come from a small frame model.
module tb_gb_stream_tx;

    localparam int DW = 14;
    localparam int MW = 16;
`ifdef GB_STREAM_TX_CTRL_PKT_EN
    localparam int CB = 10;
`else
    localparam int CB = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [MW-1:0] frame_width = '0;
    logic [MW-1:0] frame_height = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [DW-1:0] din_data = '0;
    logic          dout_valid;
    logic          dout_ready = 1'b1;
    logic [DW-1:0] dout_data;
    logic          dout_startofpacket;
    logic          dout_endofpacket;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gb_stream_tx #(
        .DATA_WIDTH (DW),
        .DIM_WIDTH  (MW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .frame_width        (frame_width),
        .frame_height       (frame_height),
        .din_valid          (din_valid),
        .din_ready          (din_ready),
        .din_data           (din_data),
        .dout_valid         (dout_valid),
        .dout_ready         (dout_ready),
        .dout_data          (dout_data),
        .dout_startofpacket (dout_startofpacket),
        .dout_endofpacket   (dout_endofpacket),
        .busy               (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Beat k of a frame (control beats first when enabled, then header, then pixels 0..).
    function automatic void exp_beat(input int k, input int w, input int h,
                                     output logic [DW-1:0] d, output logic s, output logic e);
        logic [15:0] w16;
        logic [15:0] h16;
        int p;
        w16 = w[15:0];
        h16 = h[15:0];
        p = k - CB;
        s = 1'b0;
        e = 1'b0;
        d = '0;
        if (k < CB) begin
            if (k == 0) begin
                d = DW'(4'hF);
                s = 1'b1;
            end else if (k <= 4) begin
                d = DW'((w16 >> (4 * (4 - k))) & 16'hF);
            end else if (k <= 8) begin
                d = DW'((h16 >> (4 * (8 - k))) & 16'hF);
            end else begin
                d = DW'(4'h3);
                e = 1'b1;
            end
        end else if (p == 0) begin
            s = 1'b1;
        end else begin
            d = DW'(p - 1);
            e = (p == w * h);
        end
    endfunction

    // mode 0: ready=1; mode 1: ready 1,0,0,1 repeating; mode 2: ready=1 with a stray start.
    // stop_after>0 ends after that many beats without the end-of-frame checks.
    task automatic run_frame(input string tag, input int w, input int h, input int mode,
                             input int stop_after);
        int cyc;
        int nbeats;
        int first_cyc;
        int last_cyc;
        bit done;
        bit xfer;
        bit prev_stall;
        logic [DW-1:0] prev_data;
        logic prev_sop;
        logic prev_eop;
        logic [DW-1:0] ed;
        logic es;
        logic ee;
        int total;
        int limit;
        total = w * h + 1 + CB;
        limit = 4 * (w * h + CB) + 40;
        frame_width  = MW'(w);
        frame_height = MW'(h);
        din_valid    = 1'b1;
        din_data     = '0;
        start        = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        nbeats = 0;
        first_cyc = -1;
        last_cyc = -1;
        done = 1'b0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_sop = 1'b0;
        prev_eop = 1'b0;
        while (!done && cyc < limit) begin
            if (mode == 1) dout_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            else dout_ready = 1'b1;
            if (mode == 2) begin
                start = (cyc == 4);
                frame_width = (cyc == 4) ? MW'(2) : MW'(w);
            end
            #1;
            if (prev_stall) begin
                check({tag, " hold_data"}, 32'(dout_data), 32'(prev_data));
                check({tag, " hold_flags"}, {30'b0, dout_startofpacket, dout_endofpacket},
                      {30'b0, prev_sop, prev_eop});
            end
            if (dout_valid && !dout_ready) check({tag, " din_ready_stall"}, 32'(din_ready), 0);
            if (dout_valid && dout_ready) begin
                exp_beat(nbeats, w, h, ed, es, ee);
                check($sformatf("%s beat%0d", tag, nbeats),
                      {16'b0, dout_startofpacket, dout_endofpacket, dout_data},
                      {16'b0, es, ee, ed});
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                nbeats++;
                if (dout_endofpacket && nbeats > CB) done = 1'b1;
                if (stop_after > 0 && nbeats == stop_after) done = 1'b1;
            end
            xfer = din_valid && din_ready;
            prev_stall = dout_valid && !dout_ready;
            prev_data = dout_data;
            prev_sop = dout_startofpacket;
            prev_eop = dout_endofpacket;
            step();
            if (xfer) din_data = din_data + DW'(1);
            cyc++;
        end
        start = 1'b0;
        frame_width = MW'(w);
        check({tag, " completed"}, 32'(done), 1);
        if (stop_after == 0) begin
            check({tag, " beat_count"}, nbeats, total);
            check({tag, " busy_after"}, 32'(busy), 0);
            check({tag, " valid_after"}, 32'(dout_valid), 0);
            if (mode == 0) check({tag, " contiguous"}, last_cyc - first_cyc + 1, total);
        end
        dout_ready = 1'b1;
    endtask

    initial begin
        bit found;
        bit xfer;
        rst = 1'b1;
        step();
        step();
        check("reset valid", 32'(dout_valid), 0);
        check("reset busy", 32'(busy), 0);
        check("reset din_ready", 32'(din_ready), 0);
        check("reset data/flags", {16'b0, dout_startofpacket, dout_endofpacket, dout_data}, 0);
        rst = 1'b0;
        step();

        run_frame("w4h2", 4, 2, 0, 0);
        run_frame("w4h2_bp", 4, 2, 1, 0);

        frame_width  = MW'(0);
        frame_height = MW'(5);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("zero_w busy", 32'(busy), 0);
            check("zero_w valid", 32'(dout_valid), 0);
            step();
        end
        run_frame("w1h1", 1, 1, 0, 0);

        // Abort on the third pixel of a 4x2 frame.
        frame_width  = MW'(4);
        frame_height = MW'(2);
        din_valid = 1'b1;
        din_data = '0;
        dout_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (din_ready && din_data == DW'(2)) begin
                found = 1'b1;
                break;
            end
            xfer = din_valid && din_ready;
            step();
            if (xfer) din_data = din_data + DW'(1);
        end
        check("abort reached_px2", 32'(found), 1);
        rst = 1'b1;
        step();
        check("abort valid", 32'(dout_valid), 0);
        check("abort busy", 32'(busy), 0);
        check("abort din_ready", 32'(din_ready), 0);
        rst = 1'b0;
        step();
        run_frame("after_abort", 4, 2, 0, 0);

        run_frame("stray_start", 3, 2, 2, 0);
        for (int i = 0; i < 4; i++) begin
            check("stray_start idle", {30'b0, busy, dout_valid}, 0);
            step();
        end

`ifdef GB_STREAM_TX_CTRL_PKT_EN
        run_frame("ctrl640x480", 640, 480, 0, 12);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
